lsu_xlen: RTL

Parametrised load/store unit between the execute stage and the data memory bus; generalises the byte/half/word/double-word access sizes and the zero-extend control of the core's control word to a configurable XLEN (32 or 64). Accepts one access at a time, aligns store data and byte enables to the bus lanes, and runs a request/grant/response handshake with memory. Returns sign- or zero-extended load data, or an alignment/illegal-size error, to writeback.

---
 rtl/lsu_xlen.sv | 123 ++++++++++++
 1 files changed

// File: rtl/lsu_xlen.sv
// Load/store unit for an XLEN-wide data bus. It handles one access at a time through
// IDLE/REQ/WAIT/RESP, aligning stores onto bus lanes and extending load results.
module lsu_xlen #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_zero_extnd,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_misaligned,
  output logic              rsp_illegal
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state, state_nx;

  logic [ADDR_W-1:0] addr_q;
  logic [NB-1:0]     be_q;
  logic [XLEN-1:0]   wdata_q, rdata_q;
  logic              we_q, zext_q, mis_q, ill_q;
  logic [OFFW-1:0]   off_q;
  logic [3:0]        nbytes_q;

  // Request decode
  logic [OFFW-1:0] off_in;
  logic [3:0]      nbytes_in;
  logic [15:0]     lane_mask;
  logic            ill_in, mis_in;
  logic [NB-1:0]   be_in;

  assign off_in    = req_addr[OFFW-1:0];
  assign nbytes_in = 4'd1 << req_size;
  assign lane_mask = (16'd1 << nbytes_in) - 16'd1;
  assign ill_in    = (req_size == 2'b11) && (XLEN == 32);
  assign mis_in    = !ill_in && (|(4'(off_in) & (nbytes_in - 4'd1)));
  assign be_in     = NB'(lane_mask) << off_in;

  // Load extraction: mask keeps the access width, its top bit is the sign
  // position; full-width accesses get an all-ones mask and pass through.
  logic [XLEN-1:0] v, mask, ext;
  logic            sgn;
  always_comb begin
    v    = mem_rdata >> {off_q, 3'b000};
    mask = (XLEN'(1) << {nbytes_q, 3'b000}) - XLEN'(1);
    sgn  = |(v & mask & ~(mask >> 1));
    ext  = (v & mask) | ((sgn && !zext_q) ? ~mask : '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_valid) state_nx = (ill_in || mis_in) ? RESP : REQ;
      REQ:  if (mem_gnt) state_nx = WAIT;
      WAIT: if (mem_rvalid) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      zext_q   <= 1'b0;
      mis_q    <= 1'b0;
      ill_q    <= 1'b0;
      off_q    <= '0;
      nbytes_q <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        addr_q   <= {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
        be_q     <= be_in;
        wdata_q  <= req_wdata << {off_in, 3'b000};
        rdata_q  <= '0;
        we_q     <= req_wr;
        zext_q   <= req_zero_extnd;
        mis_q    <= mis_in;
        ill_q    <= ill_in;
        off_q    <= off_in;
        nbytes_q <= nbytes_in;
      end
      if (state == WAIT && mem_rvalid) rdata_q <= we_q ? '0 : ext;
    end
  end

  // Outputs decode from state and registers only
  assign req_ready      = (state == IDLE);
  assign mem_req        = (state == REQ);
  assign mem_addr       = mem_req ? addr_q : '0;
  assign mem_we         = mem_req & we_q;
  assign mem_be         = mem_req ? be_q : '0;
  assign mem_wdata      = (mem_req && we_q) ? wdata_q : '0;
  assign rsp_valid      = (state == RESP);
  assign rsp_data       = rsp_valid ? rdata_q : '0;
  assign rsp_misaligned = rsp_valid & mis_q;
  assign rsp_illegal    = rsp_valid & ill_q;
endmodule
